// File: rtl/id_decode_sequencer.sv
// Decode-stage sequencer: two-entry in-order instruction queue between fetch and EX,
// plus immediate-type decode of the head instruction and a stall-cycle counter.
module id_decode_sequencer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_valid_i,
  input  logic [31:0] if_instr_i,
  input  logic [31:0] if_pc_i,
  output logic        if_ready_o,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [2:0]  imm_type_o,
  output logic        imm_used_o,
  output logic        illegal_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_U   = 3'b011;
  localparam logic [2:0] IMM_J   = 3'b100;
  localparam logic [2:0] IMM_CSR = 3'b101;

  state_e      state_q, state_d;
  logic [31:0] head_instr_q, head_instr_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] tail_instr_q, tail_instr_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [31:0] stall_q, stall_d;
  logic        enq, deq;

  assign enq = if_valid_i & if_ready_o;
  assign deq = id_valid_o & ex_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      head_instr_q <= NOP_INSTR;
      head_pc_q    <= '0;
      tail_instr_q <= NOP_INSTR;
      tail_pc_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      stall_q      <= stall_d;
    end
  end

  // Flush wins over everything: the queue empties and a same-cycle offer is dropped.
  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (enq) begin
            state_d      = ONE;
            head_instr_d = if_instr_i;
            head_pc_d    = if_pc_i;
          end
        end
        ONE: begin
          if (enq && deq) begin
            head_instr_d = if_instr_i;
            head_pc_d    = if_pc_i;
          end else if (enq) begin
            state_d      = FULL;
            tail_instr_d = if_instr_i;
            tail_pc_d    = if_pc_i;
          end else if (deq) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deq) begin
            state_d      = ONE;
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (id_valid_o && !ex_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Decode is gated by id_valid so an empty queue presents all-zero decode fields.
  always_comb begin
    if_ready_o  = (state_q != FULL) && !rst_i;
    id_valid_o  = (state_q != EMPTY);
    id_instr_o  = id_valid_o ? head_instr_q : NOP_INSTR;
    id_pc_o     = id_valid_o ? head_pc_q : 32'd0;
    stall_cnt_o = stall_q;
    imm_type_o  = IMM_I;
    imm_used_o  = 1'b0;
    illegal_o   = 1'b0;
    if (id_valid_o) begin
      case (id_instr_o[6:0])
        7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111: imm_used_o = 1'b1;
        7'b0100011, 7'b0100111: begin
          imm_type_o = IMM_S;
          imm_used_o = 1'b1;
        end
        7'b1100011: begin
          imm_type_o = IMM_B;
          imm_used_o = 1'b1;
        end
        7'b0110111, 7'b0010111: begin
          imm_type_o = IMM_U;
          imm_used_o = 1'b1;
        end
        7'b1101111: begin
          imm_type_o = IMM_J;
          imm_used_o = 1'b1;
        end
        7'b1110011: begin
          imm_type_o = id_instr_o[14] ? IMM_CSR : IMM_I;
          imm_used_o = 1'b1;
        end
        7'b0110011, 7'b1010011: imm_used_o = 1'b0;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_id_decode_sequencer.sv
// Directed bench for id_decode_sequencer: a scoreboard queue mirrors the expected
// queue contents; the head and decode fields are compared every cycle.
module tb_id_decode_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifValid;
  logic [31:0] ifInstr;
  logic [31:0] ifPc;
  logic        ifReady;
  logic        flush;
  logic        exReady;
  logic        idValid;
  logic [31:0] idInstr;
  logic [31:0] idPc;
  logic [2:0]  immType;
  logic        immUsed;
  logic        illegal;
  logic [31:0] stallCnt;

  logic [63:0] sb[$];
  int          expStall = 0;
  int          errors = 0;
  int          checks = 0;

  id_decode_sequencer #(.NOP_INSTR(NOP)) dut (
    .clk_i(clk), .rst_i(rst), .if_valid_i(ifValid), .if_instr_i(ifInstr),
    .if_pc_i(ifPc), .if_ready_o(ifReady), .flush_i(flush), .ex_ready_i(exReady),
    .id_valid_o(idValid), .id_instr_o(idInstr), .id_pc_o(idPc),
    .imm_type_o(immType), .imm_used_o(immUsed), .illegal_o(illegal),
    .stall_cnt_o(stallCnt)
  );

  always #5 clk = ~clk;

  // Reference decode: {imm_type, imm_used, illegal} for a held instruction.
  function automatic logic [4:0] decodeExp(input logic [31:0] instr);
    case (instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0000111: return {3'b000, 2'b10};
      7'b0100011, 7'b0100111:                         return {3'b001, 2'b10};
      7'b1100011:                                     return {3'b010, 2'b10};
      7'b0110111, 7'b0010111:                         return {3'b011, 2'b10};
      7'b1101111:                                     return {3'b100, 2'b10};
      7'b1110011: return instr[14] ? {3'b101, 2'b10} : {3'b000, 2'b10};
      7'b0110011, 7'b1010011:                         return {3'b000, 2'b00};
      default:                                        return {3'b000, 2'b01};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                               input logic exr, input logic fl);
    logic [63:0] head;
    logic        accept;
    int          sizeBefore;
    @(negedge clk);
    ifValid = v;
    ifInstr = instr;
    ifPc    = pc;
    exReady = exr;
    flush   = fl;
    #1;
    sizeBefore = sb.size();
    checkOutput("id_valid", {31'd0, idValid}, {31'd0, sizeBefore != 0});
    checkOutput("if_ready", {31'd0, ifReady}, {31'd0, sizeBefore < 2});
    checkOutput("stall_cnt", stallCnt, expStall);
    if (sizeBefore == 0) begin
      checkOutput("idle_instr", idInstr, NOP);
      checkOutput("idle_pc", idPc, 32'd0);
      checkOutput("idle_decode", {27'd0, immType, immUsed, illegal}, 32'd0);
    end else begin
      head = sb[0];
      checkOutput("head_instr", idInstr, head[63:32]);
      checkOutput("head_pc", idPc, head[31:0]);
      checkOutput("head_decode", {27'd0, immType, immUsed, illegal},
                  {27'd0, decodeExp(head[63:32])});
    end
    accept = v && (sizeBefore < 2);
    if (sizeBefore != 0 && !exr) expStall++;
    if (sizeBefore != 0 && exr) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (accept) sb.push_back({instr, pc});
    @(posedge clk);
  endtask

  task automatic checkResetValues();
    checkOutput("rst_id_valid", {31'd0, idValid}, 32'd0);
    checkOutput("rst_if_ready", {31'd0, ifReady}, 32'd0);
    checkOutput("rst_id_instr", idInstr, NOP);
    checkOutput("rst_id_pc", idPc, 32'd0);
    checkOutput("rst_decode", {27'd0, immType, immUsed, illegal}, 32'd0);
    checkOutput("rst_stall_cnt", stallCnt, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ifValid = 1'b0;
    ifInstr = '0;
    ifPc = '0;
    flush = 1'b0;
    exReady = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkResetValues();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_if_ready", {31'd0, ifReady}, 32'd1);

    // Single addi through an idle queue
    applyStimulus(1'b1, 32'h0050_0093, 32'h100, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Fill while EX stalls, offer a third that must be refused, then drain in order
    applyStimulus(1'b1, 32'h0000_006F, 32'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00C0_0063, 32'h204, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0037, 32'h208, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Streaming in ONE: simultaneous enqueue and dequeue
    applyStimulus(1'b1, 32'h0010_0093, 32'h300, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, {12'(i + 1), 5'd0, 3'd0, 5'd1, 7'b0010011}, 32'h300 + 32'(4 * i),
                    1'b1, 1'b0);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush from FULL with a same-cycle offer
    applyStimulus(1'b1, 32'h0000_2083, 32'h500, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0011_2023, 32'h504, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_12B7, 32'h508, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while EX takes the head: the handoff stands, the rest is dropped
    applyStimulus(1'b1, 32'h0000_0017, 32'h600, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0067, 32'h604, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Decode corner cases
    applyStimulus(1'b1, 32'h3401_5073, 32'h400, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h3401_1073, 32'h404, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0020_81B3, 32'h408, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_007F, 32'h40C, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0053, 32'h410, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_0027, 32'h414, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while FULL and stalled
    applyStimulus(1'b1, 32'h0000_006F, 32'h700, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000_0063, 32'h704, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues();
    sb.delete();
    expStall = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_if_ready", {31'd0, ifReady}, 32'd1);
    checkOutput("post_rst_stall_cnt", stallCnt, 32'd0);
    applyStimulus(1'b1, 32'h0050_0093, 32'h800, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_decode_sequencer.md
ID_DECODE_SEQUENCER -- requirements
Module: ID_DecodeSequencer

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013, value driven on id_instr when no instruction is held.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 if_valid  input  1  fetch offers an instruction this cycle.
REQ-005 if_instr  input  32  fetched instruction word.
REQ-006 if_pc  input  32  PC of the fetched instruction.
REQ-007 if_ready  output  1  sequencer accepts the offered instruction this cycle.
REQ-008 flush  input  1  synchronous flush (branch/jump redirect) of all held instructions.
REQ-009 ex_ready  input  1  EX stage accepts the presented instruction this cycle.
REQ-010 id_valid  output  1  head instruction presented to EX and the immediate generator.
REQ-011 id_instr  output  32  head instruction word; drives the immediate generator instruction input.
REQ-012 id_pc  output  32  PC of the head instruction.
REQ-013 imm_type  output  3  immediate type for the head: I=000, S=001, B=010, U=011, J=100, CSR=101.
REQ-014 imm_used  output  1  head instruction carries an immediate.
REQ-015 illegal  output  1  head opcode is not recognised.
REQ-016 stall_cnt  output  32  count of cycles with id_valid=1 and ex_ready=0.

Function
REQ-017 Two-entry in-order queue of {instr, pc}; occupancy state machine EMPTY, ONE, FULL.
REQ-018 if_ready = (state != FULL) and rst low; purely a function of registered state, never of ex_ready.
REQ-019 Enqueue when if_valid and if_ready; dequeue when id_valid and ex_ready.
REQ-020 Transitions: EMPTY->ONE on enqueue; ONE->FULL on enqueue without dequeue; ONE->EMPTY on dequeue without enqueue; ONE->ONE on simultaneous enqueue and dequeue; FULL->ONE on dequeue.
REQ-021 No bypass: an instruction accepted in cycle N is presented at id_valid no earlier than cycle N+1.
REQ-022 id_valid = (state != EMPTY); id_instr/id_pc are the oldest entry; id_instr = NOP_INSTR and id_pc = 0 when EMPTY.
REQ-023 While id_valid=1 and ex_ready=0, id_instr, id_pc, imm_type, imm_used, illegal hold stable.
REQ-024 Decode from id_instr[6:0]: 0010011, 0000011, 1100111, 0000111 -> I; 0100011, 0100111 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J.
REQ-025 Opcode 1110011: funct3[2]=1 -> CSR (zero-extended 5-bit uimm); otherwise I.
REQ-026 Opcodes 0110011 and 1010011: imm_type=000, imm_used=0, illegal=0.
REQ-027 Any other opcode: imm_type=000, imm_used=0, illegal=1; all decode outputs 000/0/0 when EMPTY.
REQ-028 flush has priority: next state EMPTY, both entries discarded, any same-cycle enqueue dropped, id_valid=0 from the next cycle.
REQ-029 A dequeue in a flush cycle is still a valid EX handoff; flush does not retract it.
REQ-030 stall_cnt increments by 1 per stalled cycle, saturates at 32'hFFFF_FFFF, unaffected by flush.

Reset
REQ-031 On rst assertion, immediately: state EMPTY, id_valid=0, id_instr=NOP_INSTR, id_pc=0, imm_type=000, imm_used=0, illegal=0, stall_cnt=0, if_ready=0.
REQ-032 Reset mid-operation discards all held entries; if_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 Enqueue 32'h0050_0093 (addi) at pc 0x100, ex_ready=1 -> next cycle id_valid=1, id_pc=0x100, imm_type=000, imm_used=1, then EMPTY.
REQ-034 ex_ready=0, enqueue 0x0000_006F then 0x00C0_0063 -> FULL, if_ready=0, imm_type=100 stable; stall_cnt increments each cycle; ex_ready=1 -> 100 then 010 in order.
REQ-035 State ONE, simultaneous enqueue and dequeue for 10 cycles -> stays ONE, no instruction lost or duplicated, order preserved.
REQ-036 FULL with flush=1 and if_valid=1 same cycle -> next cycle id_valid=0, id_instr=NOP_INSTR, flushed and offered instructions never presented.
REQ-037 csrrwi 0x3401_5073 -> imm_type=101; csrrw 0x3401_1073 -> 000; add 0x0020_81B3 -> imm_used=0; 0x0000_007F -> illegal=1.
REQ-038 rst asserted while FULL and stalled -> outputs reach reset values without a clock edge; after release if_ready=1, stall_cnt=0.
